// File: rtl/seq_add32_ctrl_pkg.sv
// rtl/seq_add32_ctrl_pkg.sv - shared constants and encodings for the sequential adder
package seq_add32_ctrl_pkg;

   localparam int WIDTH  = 32;
   localparam int SLICE  = 4;
   localparam int NSLICE = WIDTH / SLICE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

endpackage

// File: rtl/seq_add32_ctrl_if.sv
// rtl/seq_add32_ctrl_if.sv - operand/result handshake bundle for the sequential adder
interface seq_add32_ctrl_if #(
   parameter int WIDTH = seq_add32_ctrl_pkg::WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;
   logic             busy;

   // Requester side: presents operands, consumes results.
   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, cout, ovf, busy
   );

   // Adder side.
   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, cout, ovf, busy
   );

endinterface

// File: rtl/seq_add32_ctrl_cla.sv
// rtl/seq_add32_ctrl_cla.sv - four-bit carry-lookahead adder slice
module FourBitCLA (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // Every carry is expanded directly from generate/propagate, no ripple.
   assign c[0] = cin_i;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign sum_o  = p ^ c[3:0];
   assign cout_o = c[4];

endmodule

// File: rtl/seq_add32_ctrl.sv
// rtl/seq_add32_ctrl.sv - 32-bit add/sub built from one time-multiplexed 4-bit CLA slice
module seq_add32_ctrl #(
   parameter int WIDTH = seq_add32_ctrl_pkg::WIDTH,
   parameter int SLICE = seq_add32_ctrl_pkg::SLICE
) (
   input  logic                 clk,
   input  logic                 reset,
   seq_add32_ctrl_if.slave      bus
);

   import seq_add32_ctrl_pkg::state_t;
   import seq_add32_ctrl_pkg::ST_IDLE;
   import seq_add32_ctrl_pkg::ST_RUN;
   import seq_add32_ctrl_pkg::ST_DONE;
   import seq_add32_ctrl_pkg::op_t;
   import seq_add32_ctrl_pkg::OP_SUB;

   localparam int NSL  = WIDTH / SLICE;
   localparam int IDXW = $clog2(NSL);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [IDXW-1:0]  idx_q, idx_d;

   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE-1:0] slice_sum;
   logic             slice_cout;

   // The single adder slice walks the operands LSB-first, one nibble per RUN cycle.
   assign slice_a = opa_q[SLICE*idx_q +: SLICE];
   assign slice_b = opb_q[SLICE*idx_q +: SLICE];

   FourBitCLA u_cla (
      .a_i    (slice_a),
      .b_i    (slice_b),
      .cin_i  (carry_q),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
   );

   // Next-state and datapath updates; subtraction is a + ~b + 1 via the carry seed.
   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      idx_d    = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               opa_d   = bus.a;
               opb_d   = bus.b ^ {WIDTH{bus.sub}};
               carry_d = (op_t'(bus.sub) == OP_SUB);
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            result_d[SLICE*idx_q +: SLICE] = slice_sum;
            carry_d = slice_cout;
            if (idx_q == LAST_IDX) begin
               // Signed overflow: like-signed operands producing an opposite-signed result.
               ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                         (slice_sum[SLICE-1] != opa_q[WIDTH-1]);
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset wins over any handshake in flight and aborts silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         idx_q    <= idx_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q == ST_RUN);
   assign bus.result    = result_q;
   assign bus.cout      = carry_q;
   assign bus.ovf       = ovf_q;

endmodule
